// File: rtl/uart_tx_if.sv
// Byte handshake between the system side and the UART transmitter.
interface uart_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB-first, optional parity, 1 stop bit.
// Every output except tx_ready is registered. The registers are loaded from the
// next-state values, so the line changes on the same edge as the state.
module uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      tx_serial,
    output logic      tx_active,
    output logic      tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          serial_nxt, active_nxt, done_nxt;
    logic          bit_end;

    assign bit_end      = (cnt == CNT_LAST);
    assign bus.tx_ready = (state == IDLE) && !rst;

    // Next-state logic: baud counter, bit index and byte capture.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        case (state)
            IDLE: begin
                if (bus.tx_valid && bus.tx_ready) begin
                    shreg_nxt = bus.tx_data;
                    cnt_nxt   = '0;
                    idx_nxt   = 3'd0;
                    state_nxt = START;
                end
            end
            START: begin
                cnt_nxt = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                cnt_nxt = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    // Index holds at 7 after the last data bit.
                    if (idx == 3'd7) state_nxt = PARITY_EN ? PARITY : STOP;
                    else             idx_nxt   = idx + 3'd1;
                end
            end
            PARITY: begin
                cnt_nxt = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                cnt_nxt = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) state_nxt = CLEANUP;
            end
            CLEANUP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output values for the state being entered, so they register with it.
    always_comb begin
        serial_nxt = 1'b1;
        active_nxt = 1'b0;
        done_nxt   = 1'b0;
        case (state_nxt)
            START: begin
                serial_nxt = 1'b0;
                active_nxt = 1'b1;
            end
            DATA: begin
                serial_nxt = shreg_nxt[idx_nxt];
                active_nxt = 1'b1;
            end
            PARITY: begin
                serial_nxt = (^shreg_nxt) ^ PARITY_ODD;
                active_nxt = 1'b1;
            end
            STOP:    active_nxt = 1'b1;
            CLEANUP: done_nxt   = 1'b1;
            default: ;
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= 3'd0;
            shreg     <= 8'h00;
            tx_serial <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shreg     <= shreg_nxt;
            tx_serial <= serial_nxt;
            tx_active <= active_nxt;
            tx_done   <= done_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (C=87 plain, C=16 even parity, C=16 odd parity).
module tb_uart_tx;
    localparam int CA = 87;
    localparam int CP = 16;

    logic       clk;
    logic       rst;
    logic [2:0] valid;
    logic [7:0] data [3];
    logic [2:0] ready, serial, active, done;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_if ifa ();
    uart_tx_if ife ();
    uart_tx_if ifo ();

    assign ifa.tx_valid = valid[0];
    assign ifa.tx_data  = data[0];
    assign ready[0]     = ifa.tx_ready;
    assign ife.tx_valid = valid[1];
    assign ife.tx_data  = data[1];
    assign ready[1]     = ife.tx_ready;
    assign ifo.tx_valid = valid[2];
    assign ifo.tx_data  = data[2];
    assign ready[2]     = ifo.tx_ready;

    uart_tx #(.CLKS_PER_BIT(CA), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave),
        .tx_serial(serial[0]), .tx_active(active[0]), .tx_done(done[0]));
    uart_tx #(.CLKS_PER_BIT(CP), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_e (
        .clk(clk), .rst(rst), .bus(ife.slave),
        .tx_serial(serial[1]), .tx_active(active[1]), .tx_done(done[1]));
    uart_tx #(.CLKS_PER_BIT(CP), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_o (
        .clk(clk), .rst(rst), .bus(ifo.slave),
        .tx_serial(serial[2]), .tx_active(active[2]), .tx_done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference frame, bit 0 = start, then D0..D7, then parity (if any), then stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit pe, input bit po);
        logic [10:0] f;
        int ones;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        ones = $countones(b);
        if (pe) f[9] = ((ones % 2) == 1) ^ po;
        return f;
    endfunction

    // Line decoder on instance A, acting as the far-end receiver in loopback.
    logic [7:0] rx_q [$];
    bit rx_en = 1'b0;
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rx_en && !rst && serial[0] === 1'b0) begin
                repeat (CA / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CA) @(negedge clk);
                    b[i] = serial[0];
                end
                repeat (CA) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    // Follows one frame cycle by cycle starting the cycle after acceptance.
    task automatic capture(input int d, input int c, input bit pe, input bit po,
                           input logic [7:0] b, input int alt_at, input logic [7:0] alt,
                           input string name, output logic [10:0] mid);
        int nb, total, bad, first_bad, done_k, done_n, ready_k;
        logic [10:0] exp;
        logic exp_line;
        nb = pe ? 11 : 10;
        total = nb * c;
        exp = frame_bits(b, pe, po);
        mid = '1;
        bad = 0; first_bad = -1; done_k = -1; done_n = 0; ready_k = -1;
        for (int k = 1; k <= total + 2; k++) begin
            @(negedge clk);
            if (k == alt_at) data[d] = alt;
            exp_line = (k <= total) ? exp[(k-1)/c] : 1'b1;
            if (serial[d] !== exp_line || active[d] !== (k <= total)) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (k <= total && (k-1) % c == c / 2) mid[(k-1)/c] = serial[d];
            if (done[d] === 1'b1) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (ready[d] === 1'b1 && ready_k < 0) ready_k = k;
        end
        chk({name, " line/active bad cycles"}, bad, 0);
        if (bad != 0) $display("  %s first bad cycle offset %0d", name, first_bad);
        chk({name, " mid-bit samples"}, mid, exp);
        chk({name, " done offset"}, done_k, total + 1);
        chk({name, " done pulses"}, done_n, 1);
        chk({name, " ready offset"}, ready_k, total + 2);
    endtask

    task automatic wait_ready(input int d);
        int t;
        t = 0;
        @(negedge clk);
        while (ready[d] !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("ready wait", ready[d], 1);
    endtask

    task automatic send(input int d, input int c, input bit pe, input bit po,
                        input logic [7:0] b, input string name, output logic [10:0] mid);
        wait_ready(d);
        valid[d] = 1'b1;
        data[d]  = b;
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        data[d]  = 8'($urandom);
        capture(d, c, pe, po, b, 0, 8'h00, name, mid);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    initial begin
        vec_t vecs [5];
        logic [10:0] mid;
        logic [7:0] rb;
        int cnt;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h3C, 10'b1001111000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h00, 10'b1000000000};
        vecs[4] = '{8'h5A, 10'b1010110100};

        valid = 3'b000;
        for (int i = 0; i < 3; i++) data[i] = 8'h00;

        // Reset for three cycles
        rst = 1'b1;
        #1;
        chk("ready during reset (pre-edge)", ready, 3'b000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready during reset", ready, 3'b000);
        chk("serial in reset", serial, 3'b111);
        chk("active in reset", active, 3'b000);
        chk("done in reset", done, 3'b000);
        rst = 1'b0;
        @(negedge clk);
        chk("ready after release", ready, 3'b111);
        chk("serial after release", serial, 3'b111);

        // Table-driven frames at C=87
        foreach (vecs[i]) begin
            send(0, CA, 1'b0, 1'b0, vecs[i].data, $sformatf("vec%0d", i), mid);
            chk($sformatf("vec%0d table frame", i), mid[9:0], vecs[i].frame);
        end

        // Parity sense with 0x07
        send(1, CP, 1'b1, 1'b0, 8'h07, "par_even", mid);
        chk("par_even parity bit", mid[9], 1'b1);
        chk("par_even stop bit", mid[10], 1'b1);
        send(2, CP, 1'b1, 1'b1, 8'h07, "par_odd", mid);
        chk("par_odd parity bit", mid[9], 1'b0);
        chk("par_odd stop bit", mid[10], 1'b1);

        // Busy ignore: valid held, data changed mid-frame
        wait_ready(0);
        valid[0] = 1'b1;
        data[0]  = 8'h11;
        @(posedge clk);
        #1;
        capture(0, CA, 1'b0, 1'b0, 8'h11, 400, 8'h22, "busy_first", mid);
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        capture(0, CA, 1'b0, 1'b0, 8'h22, 0, 8'h00, "busy_second", mid);

        // Loopback back-to-back 0x3C then 0xFF
        rx_q.delete();
        rx_en = 1'b1;
        wait_ready(0);
        valid[0] = 1'b1;
        data[0]  = 8'h3C;
        @(posedge clk);
        #1;
        capture(0, CA, 1'b0, 1'b0, 8'h3C, 10, 8'hFF, "loop_first", mid);
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        capture(0, CA, 1'b0, 1'b0, 8'hFF, 0, 8'h00, "loop_second", mid);
        repeat (5) @(negedge clk);
        rx_en = 1'b0;
        chk("loopback byte count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("loopback byte 0", rx_q[0], 8'h3C);
            chk("loopback byte 1", rx_q[1], 8'hFF);
        end

        // Reset during data bit 3 of 0x00
        wait_ready(0);
        valid[0] = 1'b1;
        data[0]  = 8'h00;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        repeat (4 * CA + 40) @(negedge clk);
        chk("mid-frame line low", serial[0], 1'b0);
        chk("mid-frame active", active[0], 1'b1);
        rst = 1'b1;
        #1;
        chk("ready while rst", ready[0], 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("line high after reset", serial[0], 1'b1);
        chk("active low after reset", active[0], 1'b0);
        chk("ready after mid reset", ready[0], 1'b1);
        cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (done[0] === 1'b1 || serial[0] !== 1'b1) cnt++;
        end
        chk("abandoned frame quiet", cnt, 0);
        send(0, CA, 1'b0, 1'b0, 8'h5A, "after_reset", mid);
        chk("after_reset frame", mid[9:0], 10'b1010110100);

        // Randomized bytes on the parity instances
        for (int r = 0; r < 6; r++) begin
            for (int d = 1; d < 3; d++) begin
                rb = 8'($urandom);
                repeat ($urandom_range(0, 4)) @(negedge clk);
                send(d, CP, 1'b1, (d == 2), rb, $sformatf("rand%0d_%0d_%0h", r, d, rb), mid);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
